// File: rtl/tri_fill_scheduler.sv
// tri_fill_scheduler: command-side controller for the triangle filler.
// Round-robin accepts draw commands from two requesters, runs one filler
// pass per command, forwards the pixel stream and reports completion.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        per-requester command handshake (ready one-hot)
//   req_v0..req_v2             packed vertices, requester i at [i*W +: W]
//   fill_start, fill_v0..v3    filler control and vertices (v3 tied to 0)
//   fill_x/y/valid/ready/done  filler pixel stream and completion level
//   pix_x/y/valid/ready        forwarded pixel stream to framebuffer writer
//   cmp_valid/id/count/err     per-triangle completion report
//   busy                       high whenever not idle
module tri_fill_scheduler #(
    parameter int VERTEX_DATA_WIDTH = 32,
    parameter int PIXEL_ADDR_WIDTH  = 16,
    parameter int COUNT_WIDTH       = 20,
    parameter int TIMEOUT_CYCLES    = 4096
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [1:0]                     req_valid,
    output logic [1:0]                     req_ready,
    input  logic [2*VERTEX_DATA_WIDTH-1:0] req_v0,
    input  logic [2*VERTEX_DATA_WIDTH-1:0] req_v1,
    input  logic [2*VERTEX_DATA_WIDTH-1:0] req_v2,
    output logic                           fill_start,
    output logic [VERTEX_DATA_WIDTH-1:0]   fill_v0,
    output logic [VERTEX_DATA_WIDTH-1:0]   fill_v1,
    output logic [VERTEX_DATA_WIDTH-1:0]   fill_v2,
    output logic [VERTEX_DATA_WIDTH-1:0]   fill_v3,
    output logic                           fill_ready,
    input  logic [PIXEL_ADDR_WIDTH-1:0]    fill_x,
    input  logic [PIXEL_ADDR_WIDTH-1:0]    fill_y,
    input  logic                           fill_valid,
    input  logic                           fill_done,
    output logic [PIXEL_ADDR_WIDTH-1:0]    pix_x,
    output logic [PIXEL_ADDR_WIDTH-1:0]    pix_y,
    output logic                           pix_valid,
    input  logic                           pix_ready,
    output logic                           cmp_valid,
    output logic                           cmp_id,
    output logic [COUNT_WIDTH-1:0]         cmp_count,
    output logic                           cmp_err,
    output logic                           busy
);

    localparam int VW   = VERTEX_DATA_WIDTH;
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0]        WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_REL,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic                   last_q, last_d;
    logic [VW-1:0]          v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
    logic                   id_q, id_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic                   err_q, err_d;
    logic                   cid_q, cid_d;
    logic [COUNT_WIDTH-1:0] ccnt_q, ccnt_d;
    logic                   cerr_q, cerr_d;
    logic                   gidx;
    logic                   xfer;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        v0_d       = v0_q;
        v1_d       = v1_q;
        v2_d       = v2_q;
        id_d       = id_q;
        cnt_d      = cnt_q;
        wd_d       = wd_q;
        err_d      = err_q;
        cid_d      = cid_q;
        ccnt_d     = ccnt_q;
        cerr_d     = cerr_q;
        gidx       = 1'b0;
        xfer       = 1'b0;
        req_ready  = 2'b00;
        fill_start = 1'b0;
        fill_ready = 1'b0;
        pix_valid  = 1'b0;
        pix_x      = '0;
        pix_y      = '0;
        unique case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    // last_q holds the previous winner; on contention the other side wins
                    gidx      = (&req_valid) ? ~last_q : req_valid[1];
                    // no accept can be signalled while reset is being applied
                    req_ready = reset ? 2'b00 : (2'b01 << gidx);
                    v0_d      = gidx ? req_v0[2*VW-1:VW] : req_v0[VW-1:0];
                    v1_d      = gidx ? req_v1[2*VW-1:VW] : req_v1[VW-1:0];
                    v2_d      = gidx ? req_v2[2*VW-1:VW] : req_v2[VW-1:0];
                    id_d      = gidx;
                    last_d    = gidx;
                    cnt_d     = '0;
                    wd_d      = '0;
                    err_d     = 1'b0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                fill_start = 1'b1;
                fill_ready = pix_ready;
                pix_valid  = fill_valid;
                pix_x      = fill_x;
                pix_y      = fill_y;
                xfer       = fill_valid & pix_ready;
                if (xfer && cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // a downstream stall is not filler misbehaviour
                if (xfer || !pix_ready) begin
                    wd_d = '0;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
                if (fill_done) begin
                    err_d   = 1'b0;
                    state_d = S_REL;
                end else if (!xfer && pix_ready && wd_q == WD_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_REL;
                end
            end
            S_REL: begin
                if (!fill_done) begin
                    cid_d   = id_q;
                    ccnt_d  = cnt_q;
                    cerr_d  = err_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            v0_q    <= '0;
            v1_q    <= '0;
            v2_q    <= '0;
            id_q    <= 1'b0;
            cnt_q   <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            cid_q   <= 1'b0;
            ccnt_q  <= '0;
            cerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            cid_q   <= cid_d;
            ccnt_q  <= ccnt_d;
            cerr_q  <= cerr_d;
        end
    end

    assign fill_v0   = v0_q;
    assign fill_v1   = v1_q;
    assign fill_v2   = v2_q;
    assign fill_v3   = '0;
    assign cmp_valid = (state_q == S_DONE);
    assign cmp_id    = cid_q;
    assign cmp_count = ccnt_q;
    assign cmp_err   = cerr_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_tri_fill_scheduler.sv
// tb_tri_fill_scheduler: directed bench for tri_fill_scheduler.
// Drives a hand-written filler stub and checks handshakes and completions.
module tb_tri_fill_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_v0, req_v1, req_v2;
    logic        fill_start;
    logic [31:0] fill_v0, fill_v1, fill_v2, fill_v3;
    logic        fill_ready;
    logic [15:0] fill_x, fill_y;
    logic        fill_valid, fill_done;
    logic [15:0] pix_x, pix_y;
    logic        pix_valid, pix_ready;
    logic        cmp_valid, cmp_id, cmp_err;
    logic [19:0] cmp_count;
    logic        busy;

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    int npv, xfers, idx, bad;
    logic stalled;

    always #5 clk = ~clk;

    tri_fill_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_v0     (req_v0),
        .req_v1     (req_v1),
        .req_v2     (req_v2),
        .fill_start (fill_start),
        .fill_v0    (fill_v0),
        .fill_v1    (fill_v1),
        .fill_v2    (fill_v2),
        .fill_v3    (fill_v3),
        .fill_ready (fill_ready),
        .fill_x     (fill_x),
        .fill_y     (fill_y),
        .fill_valid (fill_valid),
        .fill_done  (fill_done),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .cmp_valid  (cmp_valid),
        .cmp_id     (cmp_id),
        .cmp_count  (cmp_count),
        .cmp_err    (cmp_err),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one full command from the IDLE cycle through the DONE cycle
    task automatic do_tri(input logic [1:0] rv, input logic g,
                          input int npix);
        req_valid = rv;
        #1;
        chk("rr_ready", 32'(req_ready), g ? 32'd2 : 32'd1);
        step();
        #1;
        chk("rr_start", 32'(fill_start), 32'd1);
        chk("rr_v0", fill_v0, g ? 32'h1111_1111 : 32'h0000_00A0);
        chk("rr_v2", fill_v2, g ? 32'h3333_3333 : 32'h0000_00C0);
        pix_ready = 1'b1;
        for (int i = 0; i < npix; i++) begin
            fill_valid = 1'b1;
            fill_x     = 16'(i);
            step();
        end
        fill_valid = 1'b0;
        fill_done  = 1'b1;
        step();
        #1;
        chk("rr_rel_start", 32'(fill_start), 32'd0);
        chk("rr_rel_ready", 32'(req_ready), 32'd0);
        fill_done = 1'b0;
        step();
        #1;
        chk("rr_cmp_valid", 32'(cmp_valid), 32'd1);
        chk("rr_cmp_id", 32'(cmp_id), 32'(g));
        chk("rr_cmp_count", 32'(cmp_count), 32'(npix));
        chk("rr_cmp_err", 32'(cmp_err), 32'd0);
        chk("rr_done_ready", 32'(req_ready), 32'd0);
        step();
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 2'b00;
        req_v0     = '0;
        req_v1     = '0;
        req_v2     = '0;
        fill_x     = '0;
        fill_y     = '0;
        fill_valid = 1'b0;
        fill_done  = 1'b0;
        pix_ready  = 1'b0;
        repeat (2) step();

        // reset state, with a request pending
        req_valid = 2'b01;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(fill_start), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_cmp_valid", 32'(cmp_valid), 32'd0);
        chk("rst_cmp_count", 32'(cmp_count), 32'd0);
        chk("rst_fill_v0", fill_v0, 32'd0);
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);

        // single command, 9 pixels
        req_v0 = {32'h0, 32'h0001_0001};
        req_v1 = {32'h0, 32'h0005_0005};
        req_v2 = {32'h0, 32'h0001_0005};
        reset  = 1'b0;
        #1;
        chk("t1_ready", 32'(req_ready), 32'd1);
        chk("t1_start_pre", 32'(fill_start), 32'd0);
        step();
        req_valid = 2'b00;
        #1;
        chk("t1_start", 32'(fill_start), 32'd1);
        chk("t1_ready_drop", 32'(req_ready), 32'd0);
        chk("t1_v0", fill_v0, 32'h0001_0001);
        chk("t1_v1", fill_v1, 32'h0005_0005);
        chk("t1_v2", fill_v2, 32'h0001_0005);
        chk("t1_v3", fill_v3, 32'h0);
        chk("t1_busy", 32'(busy), 32'd1);
        pix_ready = 1'b1;
        npv = 0;
        for (int i = 0; i < 9; i++) begin
            fill_valid = 1'b1;
            fill_x     = 16'(i);
            fill_y     = 16'(i + 1);
            #1;
            if (pix_valid && fill_ready && pix_x == 16'(i) &&
                pix_y == 16'(i + 1)) npv++;
            step();
        end
        chk("t1_pixels", 32'(npv), 32'd9);
        fill_valid = 1'b0;
        fill_done  = 1'b1;
        step();
        #1;
        chk("t1_rel_start", 32'(fill_start), 32'd0);
        chk("t1_rel_fready", 32'(fill_ready), 32'd0);
        chk("t1_rel_cmp", 32'(cmp_valid), 32'd0);
        fill_done = 1'b0;
        step();
        #1;
        chk("t1_cmp_valid", 32'(cmp_valid), 32'd1);
        chk("t1_cmp_id", 32'(cmp_id), 32'd0);
        chk("t1_cmp_count", 32'(cmp_count), 32'd9);
        chk("t1_cmp_err", 32'(cmp_err), 32'd0);
        step();
        #1;
        chk("t1_cmp_pulse", 32'(cmp_valid), 32'd0);
        chk("t1_cmp_hold", 32'(cmp_count), 32'd9);
        chk("t1_idle", 32'(busy), 32'd0);

        // round-robin: both requesters busy for 8 commands
        reset = 1'b1;
        step();
        reset  = 1'b0;
        req_v0 = {32'h1111_1111, 32'h0000_00A0};
        req_v1 = {32'h2222_2222, 32'h0000_00B0};
        req_v2 = {32'h3333_3333, 32'h0000_00C0};
        for (int k = 0; k < 8; k++) begin
            do_tri(2'b11, 1'(k % 2), k + 1);
        end
        req_valid = 2'b00;

        // backpressure with a long downstream stall
        req_valid = 2'b01;
        #1;
        chk("bp_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 2'b00;
        idx = 0;
        xfers = 0;
        bad = 0;
        stalled = 1'b0;
        for (int c = 0; c < 100 && idx < 5; c++) begin
            if (idx == 2 && !stalled) begin
                stalled    = 1'b1;
                pix_ready  = 1'b0;
                fill_valid = 1'b1;
                fill_x     = 16'(idx);
                for (int s = 0; s < 10000; s++) begin
                    #1;
                    if (fill_ready || !fill_start) bad++;
                    step();
                end
                chk("bp_stall", 32'(bad), 32'd0);
            end
            pix_ready  = (c % 4 == 0) || (c % 4 == 3);
            fill_valid = 1'b1;
            fill_x     = 16'(idx);
            fill_y     = 16'(idx) ^ 16'hFFFF;
            #1;
            if (pix_valid && pix_ready) begin
                if (pix_x != 16'(idx) || pix_y != (16'(idx) ^ 16'hFFFF)) bad++;
                xfers++;
                idx++;
            end
            step();
        end
        chk("bp_xfers", 32'(xfers), 32'd5);
        chk("bp_order", 32'(bad), 32'd0);
        fill_valid = 1'b0;
        fill_done  = 1'b1;
        pix_ready  = 1'b1;
        step();
        fill_done = 1'b0;
        step();
        #1;
        chk("bp_cmp_valid", 32'(cmp_valid), 32'd1);
        chk("bp_cmp_count", 32'(cmp_count), 32'd5);
        chk("bp_cmp_err", 32'(cmp_err), 32'd0);
        step();

        // watchdog: filler never responds
        req_valid = 2'b10;
        #1;
        chk("wd_ready", 32'(req_ready), 32'd2);
        step();
        req_valid  = 2'b00;
        pix_ready  = 1'b1;
        fill_valid = 1'b0;
        bad = 0;
        for (int k = 0; k < 4096; k++) begin
            #1;
            if (!fill_start || cmp_valid) bad++;
            step();
        end
        #1;
        chk("wd_hold", 32'(bad), 32'd0);
        chk("wd_drop", 32'(fill_start), 32'd0);
        step();
        #1;
        chk("wd_cmp_valid", 32'(cmp_valid), 32'd1);
        chk("wd_cmp_err", 32'(cmp_err), 32'd1);
        chk("wd_cmp_count", 32'(cmp_count), 32'd0);
        chk("wd_cmp_id", 32'(cmp_id), 32'd1);
        step();
        do_tri(2'b01, 1'b0, 2);
        req_valid = 2'b00;

        // done coincident with the last pixel, done held longer
        req_valid = 2'b01;
        #1;
        chk("dp_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 2'b00;
        pix_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            fill_valid = 1'b1;
            step();
        end
        fill_valid = 1'b1;
        fill_done  = 1'b1;
        #1;
        chk("dp_pix", 32'(pix_valid), 32'd1);
        step();
        fill_valid = 1'b0;
        req_valid  = 2'b01;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (fill_start || req_ready != 2'b00 || cmp_valid) bad++;
            step();
        end
        chk("dp_rel_hold", 32'(bad), 32'd0);
        fill_done = 1'b0;
        step();
        #1;
        chk("dp_cmp_valid", 32'(cmp_valid), 32'd1);
        chk("dp_cmp_count", 32'(cmp_count), 32'd3);
        chk("dp_done_ready", 32'(req_ready), 32'd0);
        step();
        #1;
        chk("dp_next_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 2'b00;
        #1;
        chk("dp_next_start", 32'(fill_start), 32'd1);

        // reset in the middle of a run after 3 pixels
        for (int i = 0; i < 3; i++) begin
            fill_valid = 1'b1;
            step();
        end
        fill_valid = 1'b0;
        reset = 1'b1;
        step();
        #1;
        chk("mr_start", 32'(fill_start), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_cmp", 32'(cmp_valid), 32'd0);
        reset = 1'b0;
        step();
        #1;
        chk("mr_cmp_after", 32'(cmp_valid), 32'd0);
        req_valid = 2'b11;
        #1;
        chk("mr_ptr", 32'(req_ready), 32'd1);
        step();
        req_valid = 2'b00;
        #1;
        chk("mr_restart", 32'(fill_start), 32'd1);
        fill_done = 1'b1;
        step();
        fill_done = 1'b0;
        step();
        #1;
        chk("mr_cmp_id", 32'(cmp_id), 32'd0);
        chk("mr_cmp_count", 32'(cmp_count), 32'd0);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
